// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: IF/ID pipeline register with stall/flush control, stall-run deadlock flag and event counters
module pipe_stall_ctrl #(
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hazard_detected,
  input  logic              i_branch_taken,
  input  logic [DATA_W-1:0] i_instr_F,
  input  logic [DATA_W-1:0] i_pc_plus4_F,
  output logic [DATA_W-1:0] o_instr_D,
  output logic [DATA_W-1:0] o_pc_plus4_D,
  output logic              o_valid_D,
  output logic              o_freeze_pc,
  output logic              o_bubble_E,
  output logic [1:0]        o_state,
  output logic [3:0]        o_stall_cnt,
  output logic              o_deadlock,
  output logic [15:0]       o_stall_total,
  output logic [15:0]       o_flush_total
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  state_t state, state_nxt;
  logic hz;
  logic [3:0] cnt_nxt;
  assign hz = i_hazard_detected & ~i_branch_taken;
  assign o_freeze_pc = hz;
  assign o_bubble_E = hz;
  assign o_state = state;
  always_comb begin
    state_nxt = i_branch_taken ? FLUSH : i_hazard_detected ? STALL : RUN;
    cnt_nxt = hz ? ((o_stall_cnt == 4'hf) ? 4'hf : o_stall_cnt + 4'd1) : 4'd0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else state <= state_nxt;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_instr_D     <= '0;
      o_pc_plus4_D  <= '0;
      o_valid_D     <= 1'b0;
      o_stall_cnt   <= 4'd0;
      o_deadlock    <= 1'b0;
      o_stall_total <= 16'd0;
      o_flush_total <= 16'd0;
    end else begin
      o_stall_cnt <= cnt_nxt;
      if (hz && cnt_nxt >= 4'(MAX_STALL)) o_deadlock <= 1'b1;
      if (hz) o_stall_total <= o_stall_total + 16'd1;
      if (i_branch_taken) o_flush_total <= o_flush_total + 16'd1;
      if (i_branch_taken) begin
        o_instr_D    <= '0;
        o_pc_plus4_D <= '0;
        o_valid_D    <= 1'b0;
      end else if (!hz) begin
        o_instr_D    <= i_instr_F;
        o_pc_plus4_D <= i_pc_plus4_F;
        o_valid_D    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenario tasks for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  logic clk = 1'b0, rst = 1'b0, hazard = 1'b0, branch = 1'b0;
  logic [31:0] instr_f = '0, pc_f = '0;
  logic [31:0] instr_d, pc_d;
  logic valid_d, freeze, bubble, deadlock;
  logic [1:0] state;
  logic [3:0] stall_cnt;
  logic [15:0] stall_total, flush_total;
  int passed = 0, total = 0;
  pipe_stall_ctrl #(.DATA_W(32), .MAX_STALL(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_hazard_detected(hazard), .i_branch_taken(branch),
    .i_instr_F(instr_f), .i_pc_plus4_F(pc_f), .o_instr_D(instr_d), .o_pc_plus4_D(pc_d),
    .o_valid_D(valid_d), .o_freeze_pc(freeze), .o_bubble_E(bubble), .o_state(state),
    .o_stall_cnt(stall_cnt), .o_deadlock(deadlock), .o_stall_total(stall_total),
    .o_flush_total(flush_total)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; instr_f = 32'hdead; pc_f = 32'hbeef;
    tick();
    total++; if ({instr_d, pc_d, valid_d} !== 65'd0) $display("FAIL reset_ifid got %h/%h/%b want 0", instr_d, pc_d, valid_d); else passed++;
    total++; if ({state, stall_cnt, deadlock} !== 7'd0) $display("FAIL reset_ctrl got st=%0d cnt=%0d dl=%b want 0", state, stall_cnt, deadlock); else passed++;
    total++; if ({stall_total, flush_total} !== 32'd0) $display("FAIL reset_cnt got %h/%h want 0", stall_total, flush_total); else passed++;
    rst = 1'b0;
  endtask
  task automatic test_stream();
    logic [31:0] v [3];
    v[0] = 32'h11; v[1] = 32'h22; v[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      instr_f = v[k]; pc_f = 32'h100 + 32'(4 * k);
      tick();
      total++; if (instr_d !== v[k] || pc_d !== 32'h100 + 32'(4 * k)) $display("FAIL stream_%0d got %h/%h want %h/%h", k, instr_d, pc_d, v[k], 32'h100 + 32'(4 * k)); else passed++;
      total++; if (valid_d !== 1'b1 || state !== 2'd0) $display("FAIL stream_ctl_%0d got v=%b st=%0d want 1/0", k, valid_d, state); else passed++;
    end
  endtask
  task automatic test_stall();
    instr_f = 32'h22; pc_f = 32'h204;
    tick();
    hazard = 1'b1; instr_f = 32'h99; pc_f = 32'h208;
    #1;
    total++; if (freeze !== 1'b1 || bubble !== 1'b1) $display("FAIL stall_comb got f=%b b=%b want 1/1", freeze, bubble); else passed++;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (instr_d !== 32'h22 || pc_d !== 32'h204 || valid_d !== 1'b1) $display("FAIL stall_hold_%0d got %h/%h/%b want 22/204/1", k, instr_d, pc_d, valid_d); else passed++;
      total++; if (stall_cnt !== 4'(k) || stall_total !== 16'(k) || state !== 2'd1) $display("FAIL stall_cnt_%0d got c=%0d t=%0d st=%0d want %0d/%0d/1", k, stall_cnt, stall_total, state, k, k); else passed++;
    end
    hazard = 1'b0;
    #1;
    total++; if (freeze !== 1'b0 || bubble !== 1'b0) $display("FAIL stall_release got f=%b b=%b want 0/0", freeze, bubble); else passed++;
    tick();
    total++; if (stall_cnt !== 4'd0 || stall_total !== 16'd2 || instr_d !== 32'h99 || state !== 2'd0) $display("FAIL stall_end got c=%0d t=%0d i=%h st=%0d want 0/2/99/0", stall_cnt, stall_total, instr_d, state); else passed++;
  endtask
  task automatic test_flush();
    branch = 1'b1; instr_f = 32'h44; pc_f = 32'h300;
    tick();
    total++; if (instr_d !== 32'd0 || pc_d !== 32'd0 || valid_d !== 1'b0) $display("FAIL flush_ifid got %h/%h/%b want 0/0/0", instr_d, pc_d, valid_d); else passed++;
    total++; if (state !== 2'd2 || flush_total !== 16'd1) $display("FAIL flush_state got st=%0d ft=%0d want 2/1", state, flush_total); else passed++;
    branch = 1'b0; instr_f = 32'h55; pc_f = 32'h304;
    tick();
    total++; if (state !== 2'd0 || instr_d !== 32'h55 || valid_d !== 1'b1) $display("FAIL flush_exit got st=%0d i=%h v=%b want 0/55/1", state, instr_d, valid_d); else passed++;
  endtask
  task automatic test_both();
    hazard = 1'b1; branch = 1'b1; instr_f = 32'h66;
    #1;
    total++; if (freeze !== 1'b0 || bubble !== 1'b0) $display("FAIL both_comb got f=%b b=%b want 0/0", freeze, bubble); else passed++;
    tick();
    total++; if (instr_d !== 32'd0 || valid_d !== 1'b0 || state !== 2'd2) $display("FAIL both_flush got i=%h v=%b st=%0d want 0/0/2", instr_d, valid_d, state); else passed++;
    total++; if (stall_cnt !== 4'd0 || stall_total !== 16'd2 || flush_total !== 16'd2) $display("FAIL both_cnt got c=%0d st=%0d ft=%0d want 0/2/2", stall_cnt, stall_total, flush_total); else passed++;
    hazard = 1'b0; branch = 1'b0;
  endtask
  task automatic test_deadlock();
    hazard = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    total++; if (deadlock !== 1'b0 || stall_cnt !== 4'd7) $display("FAIL dl_before got dl=%b c=%0d want 0/7", deadlock, stall_cnt); else passed++;
    tick();
    total++; if (deadlock !== 1'b1 || stall_cnt !== 4'd8) $display("FAIL dl_set got dl=%b c=%0d want 1/8", deadlock, stall_cnt); else passed++;
    for (int k = 0; k < 12; k++) tick();
    total++; if (stall_cnt !== 4'd15 || stall_total !== 16'd22) $display("FAIL dl_sat got c=%0d t=%0d want 15/22", stall_cnt, stall_total); else passed++;
    hazard = 1'b0;
    tick();
    total++; if (deadlock !== 1'b1 || stall_cnt !== 4'd0) $display("FAIL dl_sticky got dl=%b c=%0d want 1/0", deadlock, stall_cnt); else passed++;
  endtask
  task automatic test_reset_mid_stall();
    rst = 1'b1;
    tick();
    rst = 1'b0; instr_f = 32'h77; pc_f = 32'h400;
    tick();
    hazard = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    total++; if (stall_total !== 16'h00ff || state !== 2'd1 || deadlock !== 1'b1) $display("FAIL mid_pre got t=%h st=%0d dl=%b want 00ff/1/1", stall_total, state, deadlock); else passed++;
    rst = 1'b1; branch = 1'b1;
    tick();
    total++; if ({instr_d, pc_d, valid_d, state, stall_cnt, deadlock, stall_total, flush_total} !== 104'd0) $display("FAIL mid_reset got i=%h p=%h v=%b st=%0d c=%0d dl=%b t=%h f=%h want 0", instr_d, pc_d, valid_d, state, stall_cnt, deadlock, stall_total, flush_total); else passed++;
    total++; if (freeze !== 1'b0) $display("FAIL mid_comb got f=%b want 0", freeze); else passed++;
    rst = 1'b0; branch = 1'b0; hazard = 1'b0;
  endtask
  task automatic test_wrap();
    branch = 1'b1;
    for (int k = 0; k < 65535; k++) tick();
    total++; if (flush_total !== 16'hffff) $display("FAIL wrap_pre got %h want ffff", flush_total); else passed++;
    tick();
    total++; if (flush_total !== 16'h0000 || state !== 2'd2) $display("FAIL wrap got %h st=%0d want 0000/2", flush_total, state); else passed++;
    branch = 1'b0;
    tick();
    total++; if (state !== 2'd0 || stall_total !== 16'd0) $display("FAIL wrap_exit got st=%0d t=%h want 0/0", state, stall_total); else passed++;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_both();
    test_deadlock();
    test_reset_mid_stall();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the instruction and PC width.
REQ-002 The block SHALL have parameter MAX_STALL, default 8, giving the consecutive-stall count at which a deadlock is flagged (range 2..15).
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_hazard_detected  input  1  load-use/RAW stall request from the hazard detection unit.
REQ-006 i_branch_taken  input  1  branch resolved taken in EX; wrong-path fetch must be squashed.
REQ-007 i_instr_F  input  DATA_W  instruction fetched in IF.
REQ-008 i_pc_plus4_F  input  DATA_W  PC+4 of the fetched instruction.
REQ-009 o_instr_D  output  DATA_W  IF/ID register instruction.
REQ-010 o_pc_plus4_D  output  DATA_W  IF/ID register PC+4.
REQ-011 o_valid_D  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-012 o_freeze_pc  output  1  hold the PC this cycle.
REQ-013 o_bubble_E  output  1  zero the ID/EX control bits this cycle.
REQ-014 o_state  output  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
REQ-015 o_stall_cnt  output  4  current consecutive-stall count.
REQ-016 o_deadlock  output  1  sticky flag: stall run reached MAX_STALL.
REQ-017 o_stall_total, o_flush_total  output  16 each  event counters.

Function
REQ-018 Priority each cycle SHALL be i_rst > i_branch_taken > i_hazard_detected > normal advance.
REQ-019 o_freeze_pc and o_bubble_E SHALL be combinational, each equal to i_hazard_detected AND NOT i_branch_taken; zero latency.
REQ-020 Normal advance (no branch, no hazard): on the clock edge, IF/ID SHALL load i_instr_F and i_pc_plus4_F, and o_valid_D SHALL become 1.
REQ-021 Hazard without branch: IF/ID SHALL hold all contents, including o_valid_D.
REQ-022 Branch taken, regardless of hazard: IF/ID SHALL load o_instr_D=0 (NOP), o_pc_plus4_D=0, and o_valid_D=0.
REQ-023 FSM next-state rules:
- i_branch_taken -> FLUSH.
- else i_hazard_detected -> STALL.
- else -> RUN.
- FLUSH SHALL last exactly one cycle unless the branch is re-asserted.
REQ-024 o_stall_cnt SHALL increment on each cycle in which a hazard-without-branch is sampled, saturating at 15.
REQ-025 o_stall_cnt SHALL clear to 0 on any cycle without a hazard-without-branch.
REQ-026 o_deadlock SHALL set on the edge at which o_stall_cnt would reach MAX_STALL, and SHALL remain set until reset.
REQ-027 o_stall_total SHALL increment by 1 per hazard-without-branch cycle.
REQ-028 o_flush_total SHALL increment by 1 per i_branch_taken cycle.
REQ-029 Both event counters SHALL wrap modulo 2^16 (0xFFFF -> 0x0000).
REQ-030 Simultaneous hazard and branch: the block SHALL apply flush behaviour, SHALL NOT count a stall, SHALL clear o_stall_cnt, and SHALL deassert o_freeze_pc.
REQ-031 All registered outputs SHALL change only on the i_clk rising edge.

Reset
REQ-032 With i_rst high at an edge, the block SHALL set o_instr_D=0, o_pc_plus4_D=0, o_valid_D=0, o_state=RUN, o_stall_cnt=0, o_deadlock=0, o_stall_total=0, and o_flush_total=0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL override all other inputs at that edge.
REQ-034 Combinational outputs SHALL follow their inputs during reset; downstream stages gate them with reset.

Verification
REQ-035 Streaming: feed instr 0x11,0x22,0x33 with no hazard/branch -> o_instr_D shows 0x11,0x22,0x33 on successive cycles; o_valid_D=1; o_state=RUN.
REQ-036 Load-use stall: hold i_hazard_detected for 2 cycles while IF/ID=0x22 -> o_freeze_pc=o_bubble_E=1 for those cycles; o_instr_D stays 0x22; o_stall_cnt goes 1,2 then 0; o_stall_total=2.
REQ-037 Branch flush: assert i_branch_taken 1 cycle -> next o_instr_D=0, o_valid_D=0, o_state=FLUSH for 1 cycle then RUN; o_flush_total=1.
REQ-038 Simultaneous hazard+branch -> o_freeze_pc=0, IF/ID flushed, o_stall_cnt=0, o_stall_total unchanged, o_state=FLUSH.
REQ-039 Deadlock: hold hazard 20 cycles with MAX_STALL=8 -> o_deadlock=1 after 8th stall edge, o_stall_cnt saturates at 15, o_deadlock stays 1 after hazard drops until i_rst.
REQ-040 Reset mid-stall: i_rst during STALL with o_stall_total=0x00FF -> all registered outputs 0 on next edge; preload o_flush_total=0xFFFF plus one branch -> 0x0000 wrap.
